// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run sequencer for the 9-bit simple processor. It turns host start/step/halt
//   pulses into the processor's Run/Done handshake. Each instruction gets one
//   Run pulse, and the sequencer then waits for Done. It also keeps a shadow
//   pc and a retired-instruction count. A run stops on halt, breakpoint,
//   instruction limit, single-step completion or Done timeout.
//
// Ports
//   Clock        rising-edge clock shared with the processor datapath
//   Resetn       asynchronous active-low reset
//   start/step   1-cycle host commands, accepted only when idle (start wins)
//   halt         1-cycle request: stop once the in-flight instruction retires
//   bp_en        breakpoint enable
//   bp_addr      breakpoint address, compared against the post-retire pc
//   max_instr    per-run instruction limit, 0 = unlimited
//   Done         processor Done level, only looked at while waiting
//   Run          registered Run pulse to the processor
//   busy         high whenever the sequencer is not idle
//   pc           shadow instruction address (retired count mod 2^ADDR_W)
//   instr_cnt    total retired instructions, wraps
//   stop_cause   0 none, 1 halt, 2 step, 3 breakpoint, 4 limit, 5 timeout
//   err_timeout  sticky timeout flag, cleared only by reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start/step; stop_cause holds the last reason
// ISSUE   | one cycle with Run=1
// WAIT    | waiting for Done, counting towards TIMEOUT
// RETIRE  | bump pc/counters, evaluate stop conditions on updated values

module proc_run_ctrl #(
    parameter int CNT_W   = 16,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              step,
    input  logic              halt,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [CNT_W-1:0]  max_instr,
    input  logic              Done,
    output logic              Run,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [2:0]        stop_cause,
    output logic              err_timeout
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_HALT    = 3'd1;
    localparam logic [2:0] CAUSE_STEP    = 3'd2;
    localparam logic [2:0] CAUSE_BP      = 3'd3;
    localparam logic [2:0] CAUSE_LIMIT   = 3'd4;
    localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              mode_step;
    logic              halt_req;
    logic [CNT_W-1:0]  run_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              launch, launch_step;
    logic              timeout_hit, stop_hit;
    logic [2:0]        stop_code;
    logic [ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]  run_inc;

    assign pc_inc  = pc + 1'b1;
    assign run_inc = run_cnt + 1'b1;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        launch_step = 1'b0;
        timeout_hit = 1'b0;
        stop_hit    = 1'b0;
        stop_code   = CAUSE_NONE;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                    launch    = 1'b1;
                end else if (step) begin
                    state_nxt   = S_ISSUE;
                    launch      = 1'b1;
                    launch_step = 1'b1;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (Done) begin
                    state_nxt = S_RETIRE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_RETIRE: begin
                // A halt arriving in this very cycle still counts.
                if (halt_req || halt) begin
                    stop_code = CAUSE_HALT;
                end else if (bp_en && (pc_inc == bp_addr)) begin
                    stop_code = CAUSE_BP;
                end else if ((max_instr != '0) && (run_inc == max_instr)) begin
                    stop_code = CAUSE_LIMIT;
                end else if (mode_step) begin
                    stop_code = CAUSE_STEP;
                end
                stop_hit  = (stop_code != CAUSE_NONE);
                state_nxt = stop_hit ? S_IDLE : S_ISSUE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Run         <= 1'b0;
            mode_step   <= 1'b0;
            halt_req    <= 1'b0;
            run_cnt     <= '0;
            wait_cnt    <= '0;
            pc          <= '0;
            instr_cnt   <= '0;
            stop_cause  <= CAUSE_NONE;
            err_timeout <= 1'b0;
        end else begin
            // Registered Run: high exactly while the FSM sits in ISSUE.
            Run <= (state_nxt == S_ISSUE);

            if (state == S_WAIT && !Done && !timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (launch) begin
                mode_step  <= launch_step;
                stop_cause <= CAUSE_NONE;
                run_cnt    <= '0;
                halt_req   <= 1'b0;
            end else if (halt) begin
                halt_req <= 1'b1;
            end

            if (state == S_RETIRE) begin
                pc        <= pc_inc;
                instr_cnt <= instr_cnt + 1'b1;
                run_cnt   <= run_inc;
                if (stop_hit) begin
                    stop_cause <= stop_code;
                end
            end

            if (timeout_hit) begin
                stop_cause  <= CAUSE_TIMEOUT;
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
`timescale 1ns/1ps
module tb_proc_run_ctrl;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0, step = 1'b0, halt = 1'b0, bp_en = 1'b0;
    logic [4:0]  bp_addr = '0;
    logic [15:0] max_instr = '0;
    logic        Done = 1'b0;
    logic        Run, busy, err_timeout;
    logic [4:0]  pc;
    logic [15:0] instr_cnt;
    logic [2:0]  stop_cause;

    always #5 Clock = ~Clock;

    proc_run_ctrl #(.CNT_W(16), .ADDR_W(5), .TIMEOUT(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .step(step), .halt(halt),
        .bp_en(bp_en), .bp_addr(bp_addr), .max_instr(max_instr), .Done(Done),
        .Run(Run), .busy(busy), .pc(pc), .instr_cnt(instr_cnt),
        .stop_cause(stop_cause), .err_timeout(err_timeout)
    );

    int checks = 0, failures = 0;
    int pulses = 0, run_hi = 0, lat_base = 0, cur_lat0 = 1, cur_lat1 = 1, lat_left = 0;
    logic run_q = 1'b0;

    // Processor Done model: latency 0 means Done never comes.
    always @(negedge Clock) begin
        if (!Resetn) begin
            lat_left = 0;
            Done = 1'b0;
            run_q = 1'b0;
        end else begin
            if (Run) begin
                run_hi++;
                if (!run_q) begin
                    lat_left = (((pulses - lat_base) % 2) == 0) ? cur_lat0 : cur_lat1;
                    pulses++;
                end
                Done = 1'b0;
            end else if (lat_left > 0) begin
                lat_left--;
                Done = (lat_left == 0);
            end else begin
                Done = 1'b0;
            end
            run_q = Run;
        end
    end

    typedef struct {
        logic do_start, do_step, bp_en;
        int   bp_addr, max_instr, lat0, lat1;
        int   exp_pulses, exp_cnt, exp_pc, exp_cause;
    } vec_t;
    vec_t vecs[7];

    task automatic tick;
        @(negedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input logic s, input logic t);
        tick;
        start = s;
        step  = t;
        tick;
        start = 1'b0;
        step  = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            tick;
            if (!busy) break;
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_bound: got busy=1 expected busy=0", nm);
        end
    endtask

    initial begin
        int n, p0, h0;
        // in: start step bp_en bp_addr max lat0 lat1 | exp: pulses cnt pc cause
        vecs[0] = '{1'b1, 1'b0, 1'b1, 2, 0, 1, 1,  2,  2,  2, 3};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2, 0, 1, 3, 32, 34,  2, 3};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 0, 0, 1, 1,  1, 35,  3, 2};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 0, 3, 1, 3,  3, 38,  6, 4};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 7, 0, 3, 3,  1, 39,  7, 3};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 9, 2, 1, 1,  2, 41,  9, 3};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 0, 1, 3, 3,  1, 42, 10, 4};

        // Reset state
        #12;
        chk("rst_run", 32'(Run), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_cause", 32'(stop_cause), 0);
        chk("rst_err", 32'(err_timeout), 0);
        tick;
        Resetn = 1'b1;

        for (int v = 0; v < 7; v++) begin
            bp_en     = vecs[v].bp_en;
            bp_addr   = 5'(vecs[v].bp_addr);
            max_instr = 16'(vecs[v].max_instr);
            cur_lat0  = vecs[v].lat0;
            cur_lat1  = vecs[v].lat1;
            lat_base  = pulses;
            p0 = pulses;
            h0 = run_hi;
            issue(vecs[v].do_start, vecs[v].do_step);
            wait_idle($sformatf("v%0d", v), n);
            chk($sformatf("v%0d_pulses", v), 32'(pulses - p0), 32'(vecs[v].exp_pulses));
            chk($sformatf("v%0d_run_width", v), 32'(run_hi - h0), 32'(vecs[v].exp_pulses));
            chk($sformatf("v%0d_cnt", v), 32'(instr_cnt), 32'(vecs[v].exp_cnt));
            chk($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
            chk($sformatf("v%0d_cause", v), 32'(stop_cause), 32'(vecs[v].exp_cause));
        end

        // Halt during WAIT of the 2nd instruction
        bp_en = 1'b0; max_instr = '0; cur_lat0 = 3; cur_lat1 = 3;
        lat_base = pulses; p0 = pulses;
        issue(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (pulses - p0 >= 2) break;
            tick;
        end
        tick;
        halt = 1'b1;
        tick;
        halt = 1'b0;
        wait_idle("halt", n);
        chk("halt_pulses", 32'(pulses - p0), 2);
        chk("halt_cnt", 32'(instr_cnt), 44);
        chk("halt_pc", 32'(pc), 12);
        chk("halt_cause", 32'(stop_cause), 1);

        // Halt while idle does nothing; next step must report step, not halt
        p0 = pulses;
        halt = 1'b1;
        tick;
        halt = 1'b0;
        tick; tick;
        chk("idle_halt_busy", 32'(busy), 0);
        chk("idle_halt_pulses", 32'(pulses - p0), 0);
        cur_lat0 = 1; cur_lat1 = 1; lat_base = pulses;
        issue(1'b0, 1'b1);
        wait_idle("step_after_halt", n);
        chk("step_after_halt_cause", 32'(stop_cause), 2);
        chk("step_after_halt_cnt", 32'(instr_cnt), 45);

        // Done timeout
        cur_lat0 = 0; cur_lat1 = 0; lat_base = pulses;
        issue(1'b0, 1'b1);
        wait_idle("timeout", n);
        chk("timeout_wait_cycles", 32'(n), 8);
        chk("timeout_cause", 32'(stop_cause), 5);
        chk("timeout_err", 32'(err_timeout), 1);
        chk("timeout_cnt", 32'(instr_cnt), 45);
        chk("timeout_pc", 32'(pc), 13);

        // Sticky error survives a normal step
        cur_lat0 = 1; cur_lat1 = 1; lat_base = pulses;
        issue(1'b0, 1'b1);
        wait_idle("post_timeout", n);
        chk("sticky_err", 32'(err_timeout), 1);
        chk("post_timeout_cause", 32'(stop_cause), 2);
        chk("post_timeout_cnt", 32'(instr_cnt), 46);

        // Async reset mid-WAIT
        cur_lat0 = 0; cur_lat1 = 0; lat_base = pulses;
        issue(1'b0, 1'b1);
        tick; tick;
        chk("midwait_busy_before", 32'(busy), 1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("midwait_rst_busy", 32'(busy), 0);
        chk("midwait_rst_run", 32'(Run), 0);
        tick;
        chk("midwait_rst_cnt", 32'(instr_cnt), 0);
        chk("midwait_rst_err", 32'(err_timeout), 0);
        Resetn = 1'b1;

        // Async reset while Run is high
        issue(1'b0, 1'b1);
        chk("issue_run_high", 32'(Run), 1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("issue_rst_run", 32'(Run), 0);
        chk("issue_rst_busy", 32'(busy), 0);
        tick;
        Resetn = 1'b1;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
